branch_unit: RTL and testbench
==============================

Name: branch_unit

Overview:
- Parametrised successor to the combinational branch comparator in the rv32i execute stage.
- Resolves conditional branches plus JAL/JALR in one registered stage: taken decision, target address, link value, misprediction and misalignment flags.
- Valid/ready handshake on input and output; sits between execute operand muxing and the fetch redirect / writeback logic.

Parameters:
- XLEN, 32, operand/PC width (32 or 64).
- ILEN_ALIGN, 2, required target alignment in bytes (2 with C extension, 4 without); a power of two.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  request present
- in_ready  output  1  unit can accept a request
- op  input  2  00 conditional branch, 01 JAL, 10 JALR, 11 reserved
- func3  input  3  branch condition encoding per RV spec
- opa  input  XLEN  rs1 value
- opb  input  XLEN  rs2 value
- pc  input  XLEN  instruction PC
- imm  input  XLEN  sign-extended immediate
- pred_taken  input  1  fetch-stage prediction
- flush  input  1  kill the held result and any same-cycle accept
- out_valid  output  1  result held
- out_ready  input  1  consumer accepts result
- taken  output  1  branch/jump taken
- target  output  XLEN  redirect address
- link  output  XLEN  pc + 4
- mispredict  output  1  taken != pred_taken
- misaligned  output  1  taken and target not ILEN_ALIGN-aligned
- illegal  output  1  invalid func3 or op=11

Behaviour:
- Reset (async, rst_n low): state EMPTY; out_valid=0; taken, target, link, mispredict, misaligned, illegal = 0.
- FSM has two states.
  - EMPTY: in_ready=1.
  - FULL: in_ready=out_ready (a new result may replace the drained one in the same cycle).
- Accept condition: in_valid && in_ready && !flush. On accept, results are registered on that edge and the state goes FULL. Latency is 1 cycle, input accept to out_valid.
- FULL with out_ready && no accept -> EMPTY. flush in any state -> EMPTY next edge, out_valid=0, no accept that cycle.
- Conditions for op=00:
  - func3 000 EQ, 001 NE, 100 LT signed, 101 GE signed, 110 LTU, 111 GEU.
  - func3 010/011: illegal=1, taken=0.
- op=01 (JAL) and op=10 (JALR): taken=1 regardless of operands.
- op=11: illegal=1, taken=0, mispredict=0, misaligned=0.
- Target arithmetic, modulo 2^XLEN (wrap-around, no overflow flag):
  - op 00 and 01: target = pc + imm.
  - op 10: target = (opa + imm) with bit 0 cleared.
- Not-taken branches: target = pc + 4, so the consumer always redirects to target when mispredict=1.
- link = pc + 4, mod 2^XLEN.
- mispredict = (taken != pred_taken), forced 0 when illegal.
- misaligned = taken && (target mod ILEN_ALIGN != 0); checked after the JALR bit-0 clear.
- Outputs stay stable while out_valid && !out_ready. Output registers are not updated unless a request is accepted.
- Signed compare uses the full XLEN width; the MSB is the sign.

Optional Feature:
- Macro BRANCH_UNIT_STATS_EN.
- When defined, the block adds three extra output ports, stat_branches, stat_taken and stat_mispredict, each 32 bits wide.
- The counters count accepted op=00 requests, taken results and mispredicts respectively.
- Counters increment on the accept edge, wrap at 2^32, clear on reset, and are unaffected by flush.
- When undefined, the ports and logic are absent, and all other behaviour is identical.

Test Plan:
- BEQ, opa=opb=0x5, pc=0x100, imm=0x20, pred_taken=0, out_ready=1 -> next cycle: out_valid=1, taken=1, target=0x120, link=0x104, mispredict=1.
- BLT vs BLTU, opa=0xFFFFFFFF, opb=0x1 -> BLT taken=1; BLTU taken=0, target=pc+4.
- JALR, opa=0x1003, imm=0x0, ILEN_ALIGN=4 -> target=0x1002, misaligned=1. Repeat with ILEN_ALIGN=2 -> misaligned=0.
- Backpressure: out_ready=0 for 3 cycles after accept -> in_ready=0, outputs stable. Then out_ready=1 with in_valid=1 -> drain and accept in the same cycle, out_valid stays 1 with new data.
- flush while FULL with in_valid=1 -> next edge: out_valid=0, in_ready=1, request not accepted. Assert rst_n low mid-FULL -> out_valid=0 immediately, without a clock edge.
- Wrap and XLEN=64: pc=0xFFFFFFFFFFFFFFF0, imm=0x20 -> target=0x10. func3=010 -> illegal=1, taken=0, mispredict=0.

Source files
------------

// File: rtl/branch_unit.sv
// ---------------------------------------------------------------------------
// branch_unit
//   Single registered stage that resolves RV conditional branches, JAL and
//   JALR. It produces the taken decision, redirect target, link value and
//   misprediction / misalignment / illegal flags for the fetch redirect and
//   writeback logic.
//
// Parameters
//   XLEN        operand / PC width (32 or 64)
//   ILEN_ALIGN  required target alignment in bytes (power of two)
//
// Ports
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready request handshake
//   op, func3         operation select (00 branch, 01 JAL, 10 JALR, 11 rsvd)
//   opa, opb          rs1 / rs2 values
//   pc, imm           instruction PC, sign-extended immediate
//   pred_taken        fetch-stage prediction
//   flush             kill held result and any same-cycle accept
//   out_valid/out_ready result handshake
//   taken, target, link, mispredict, misaligned, illegal   registered result
//
// Optional build macro
//   BRANCH_UNIT_STATS_EN adds 32-bit counters stat_branches, stat_taken and
//   stat_mispredict (accepted op=00 requests, taken results, mispredicts).
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_valid is not required to wait for in_ready; the result
// registers hold steady while out_valid is high and out_ready is low. flush
// overrides both sides: the held result is dropped and nothing is accepted.
// ---------------------------------------------------------------------------
module branch_unit #(
    parameter int XLEN       = 32,
    parameter int ILEN_ALIGN = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      op,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] opa,
    input  logic [XLEN-1:0] opb,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic            pred_taken,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            taken,
    output logic [XLEN-1:0] target,
    output logic [XLEN-1:0] link,
    output logic            mispredict,
    output logic            misaligned,
    output logic            illegal
`ifdef BRANCH_UNIT_STATS_EN
    ,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_taken,
    output logic [31:0]     stat_mispredict
`endif
);

    localparam logic [1:0] OP_BRANCH = 2'b00;
    localparam logic [1:0] OP_JAL    = 2'b01;
    localparam logic [1:0] OP_JALR   = 2'b10;

    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(ILEN_ALIGN - 1);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic            taken_q, taken_d;
    logic [XLEN-1:0] target_q, target_d;
    logic [XLEN-1:0] link_q, link_d;
    logic            mispredict_q, mispredict_d;
    logic            misaligned_q, misaligned_d;
    logic            illegal_q, illegal_d;

    logic            accept;

    // Combinational resolution of the request currently on the inputs.
    logic            res_taken;
    logic            res_illegal;
    logic [XLEN-1:0] res_target;
    logic            res_mispredict;
    logic            res_misaligned;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] pc_rel;
    logic [XLEN-1:0] jalr_sum;
    logic            eq, lt_s, lt_u;

    always_comb begin
        pc_plus4    = pc + XLEN'(4);
        pc_rel      = pc + imm;
        jalr_sum    = opa + imm;
        eq          = (opa == opb);
        lt_s        = ($signed(opa) < $signed(opb));
        lt_u        = (opa < opb);
        res_taken   = 1'b0;
        res_illegal = 1'b0;

        case (op)
            OP_BRANCH: begin
                case (func3)
                    3'b000:  res_taken = eq;
                    3'b001:  res_taken = !eq;
                    3'b100:  res_taken = lt_s;
                    3'b101:  res_taken = !lt_s;
                    3'b110:  res_taken = lt_u;
                    3'b111:  res_taken = !lt_u;
                    default: res_illegal = 1'b1;
                endcase
            end
            OP_JAL:  res_taken = 1'b1;
            OP_JALR: res_taken = 1'b1;
            default: res_illegal = 1'b1;
        endcase

        // Not-taken (including illegal) falls through to pc+4 so the
        // consumer can always redirect to target on a mispredict.
        if (!res_taken) begin
            res_target = pc_plus4;
        end else if (op == OP_JALR) begin
            res_target = {jalr_sum[XLEN-1:1], 1'b0};
        end else begin
            res_target = pc_rel;
        end

        res_mispredict = !res_illegal && (res_taken != pred_taken);
        res_misaligned = res_taken && ((res_target & ALIGN_MASK) != '0);
    end

    // Two-state FSM: EMPTY or holding one result.
    always_comb begin
        in_ready = 1'b1;
        state_d  = state_q;
        if (state_q == ST_FULL) begin
            in_ready = out_ready;
        end
        accept = in_valid && in_ready && !flush;
        if (flush) begin
            state_d = ST_EMPTY;
        end else if (accept) begin
            state_d = ST_FULL;
        end else if ((state_q == ST_FULL) && out_ready) begin
            state_d = ST_EMPTY;
        end
    end

    // Result registers only load on accept, which keeps them stable under
    // backpressure and across flushes.
    always_comb begin
        taken_d      = taken_q;
        target_d     = target_q;
        link_d       = link_q;
        mispredict_d = mispredict_q;
        misaligned_d = misaligned_q;
        illegal_d    = illegal_q;
        if (accept) begin
            taken_d      = res_taken;
            target_d     = res_target;
            link_d       = pc_plus4;
            mispredict_d = res_mispredict;
            misaligned_d = res_misaligned;
            illegal_d    = res_illegal;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_EMPTY;
            taken_q      <= 1'b0;
            target_q     <= '0;
            link_q       <= '0;
            mispredict_q <= 1'b0;
            misaligned_q <= 1'b0;
            illegal_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            taken_q      <= taken_d;
            target_q     <= target_d;
            link_q       <= link_d;
            mispredict_q <= mispredict_d;
            misaligned_q <= misaligned_d;
            illegal_q    <= illegal_d;
        end
    end

    assign out_valid  = (state_q == ST_FULL);
    assign taken      = taken_q;
    assign target     = target_q;
    assign link       = link_q;
    assign mispredict = mispredict_q;
    assign misaligned = misaligned_q;
    assign illegal    = illegal_q;

`ifdef BRANCH_UNIT_STATS_EN
    logic [31:0] stat_branches_q, stat_branches_d;
    logic [31:0] stat_taken_q, stat_taken_d;
    logic [31:0] stat_mispredict_q, stat_mispredict_d;

    always_comb begin
        stat_branches_d   = stat_branches_q;
        stat_taken_d      = stat_taken_q;
        stat_mispredict_d = stat_mispredict_q;
        if (accept) begin
            if (op == OP_BRANCH) begin
                stat_branches_d = stat_branches_q + 32'd1;
            end
            if (res_taken) begin
                stat_taken_d = stat_taken_q + 32'd1;
            end
            if (res_mispredict) begin
                stat_mispredict_d = stat_mispredict_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_branches_q   <= '0;
            stat_taken_q      <= '0;
            stat_mispredict_q <= '0;
        end else begin
            stat_branches_q   <= stat_branches_d;
            stat_taken_q      <= stat_taken_d;
            stat_mispredict_q <= stat_mispredict_d;
        end
    end

    assign stat_branches   = stat_branches_q;
    assign stat_taken      = stat_taken_q;
    assign stat_mispredict = stat_mispredict_q;
`endif

endmodule

// File: tb/tb_branch_unit.sv
// ---------------------------------------------------------------------------
// tb_branch_unit
//   Drives two instances with identical requests: u_a (XLEN=32, align 2) and
//   u_b (XLEN=64, align 4). The 32-bit instance sees the low half of every
//   operand. Expected results are queued on accept and compared while held.
// ---------------------------------------------------------------------------
module tb_branch_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid;
    logic        flush;
    logic        out_ready;
    logic        pred_taken;
    logic [1:0]  op;
    logic [2:0]  func3;
    logic [63:0] opa, opb, pc, imm;

    logic        in_ready_a, out_valid_a, taken_a, mispredict_a, misaligned_a, illegal_a;
    logic [31:0] target_a, link_a;
    logic        in_ready_b, out_valid_b, taken_b, mispredict_b, misaligned_b, illegal_b;
    logic [63:0] target_b, link_b;

    branch_unit #(.XLEN(32), .ILEN_ALIGN(2)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
        .op(op), .func3(func3), .opa(opa[31:0]), .opb(opb[31:0]), .pc(pc[31:0]),
        .imm(imm[31:0]), .pred_taken(pred_taken), .flush(flush),
        .out_valid(out_valid_a), .out_ready(out_ready), .taken(taken_a),
        .target(target_a), .link(link_a), .mispredict(mispredict_a),
        .misaligned(misaligned_a), .illegal(illegal_a)
    );

    branch_unit #(.XLEN(64), .ILEN_ALIGN(4)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
        .op(op), .func3(func3), .opa(opa), .opb(opb), .pc(pc),
        .imm(imm), .pred_taken(pred_taken), .flush(flush),
        .out_valid(out_valid_b), .out_ready(out_ready), .taken(taken_b),
        .target(target_b), .link(link_b), .mispredict(mispredict_b),
        .misaligned(misaligned_b), .illegal(illegal_b)
    );

    typedef struct {
        logic [1:0]  op;
        logic [2:0]  f3;
        logic [63:0] opa, opb, pc, imm;
        logic        pred;
        logic        e_taken;
        logic        e_illegal;
        logic [63:0] e_target;
    } vec_t;

    vec_t           vecs[$];
    vec_t           cur;
    logic [131:0]   exp_a_q[$];
    logic [131:0]   exp_b_q[$];
    bit             m_full;
    int             n_tests = 0;
    int             n_fail  = 0;

    function automatic vec_t mk(logic [1:0] o, logic [2:0] f, logic [63:0] a,
                                logic [63:0] b, logic [63:0] p, logic [63:0] i,
                                logic pr, logic et, logic ei, logic [63:0] tg);
        vec_t v;
        v.op = o; v.f3 = f; v.opa = a; v.opb = b; v.pc = p; v.imm = i;
        v.pred = pr; v.e_taken = et; v.e_illegal = ei; v.e_target = tg;
        return v;
    endfunction

    // Packed expectation {taken, mispredict, misaligned, illegal, target, link}.
    function automatic logic [131:0] expect_of(vec_t v, int xlen, int align);
        logic [63:0] mask;
        logic [63:0] t, l;
        logic        mis, mal;
        mask = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        t    = v.e_target & mask;
        l    = (v.pc + 64'd4) & mask;
        mis  = !v.e_illegal && (v.e_taken != v.pred);
        mal  = v.e_taken && ((t % 64'(align)) != 64'd0);
        return {v.e_taken, mis, mal, v.e_illegal, t, l};
    endfunction

    function automatic logic [131:0] act_a();
        return {taken_a, mispredict_a, misaligned_a, illegal_a, 32'h0, target_a, 32'h0, link_a};
    endfunction

    function automatic logic [131:0] act_b();
        return {taken_b, mispredict_b, misaligned_b, illegal_b, target_b, link_b};
    endfunction

    task automatic chk(string name, logic [131:0] act, logic [131:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_in(vec_t v, logic valid);
        cur        = v;
        op         = v.op;
        func3      = v.f3;
        opa        = v.opa;
        opb        = v.opb;
        pc         = v.pc;
        imm        = v.imm;
        pred_taken = v.pred;
        in_valid   = valid;
    endtask

    // One clock: check handshake and held result at the falling edge, update
    // the scoreboard and reference state, then return just after the edge.
    task automatic step(string tag);
        logic rdy_e;
        logic acc;
        @(negedge clk);
        chk({tag, " out_valid_a"}, 132'(out_valid_a), 132'(m_full));
        chk({tag, " out_valid_b"}, 132'(out_valid_b), 132'(m_full));
        rdy_e = !m_full || out_ready;
        chk({tag, " in_ready_a"}, 132'(in_ready_a), 132'(rdy_e));
        chk({tag, " in_ready_b"}, 132'(in_ready_b), 132'(rdy_e));
        acc = in_valid && rdy_e && !flush;
        if (m_full && exp_a_q.size() > 0 && exp_b_q.size() > 0) begin
            chk({tag, " result_a"}, act_a(), exp_a_q[0]);
            chk({tag, " result_b"}, act_b(), exp_b_q[0]);
            if (out_ready || flush) begin
                void'(exp_a_q.pop_front());
                void'(exp_b_q.pop_front());
            end
        end
        if (acc) begin
            exp_a_q.push_back(expect_of(cur, 32, 2));
            exp_b_q.push_back(expect_of(cur, 64, 4));
        end
        if (flush)                     m_full = 1'b0;
        else if (acc)                  m_full = 1'b1;
        else if (m_full && out_ready)  m_full = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        m_full    = 1'b0;
        set_in(mk(2'b00, 3'b000, 64'h0, 64'h0, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0), 1'b0);

        //             op     f3      opa                    opb                    pc                     imm                    pr  tk  il  target
        vecs.push_back(mk(2'b00, 3'b000, 64'h5,                64'h5,                64'h100,              64'h20,               0, 1, 0, 64'h120));
        vecs.push_back(mk(2'b00, 3'b000, 64'h5,                64'h6,                64'h100,              64'h20,               0, 0, 0, 64'h104));
        vecs.push_back(mk(2'b00, 3'b001, 64'h5,                64'h6,                64'h100,              64'h20,               1, 1, 0, 64'h120));
        vecs.push_back(mk(2'b00, 3'b100, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1,             64'h200,              64'h40,               1, 1, 0, 64'h240));
        vecs.push_back(mk(2'b00, 3'b110, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1,             64'h200,              64'h40,               1, 0, 0, 64'h204));
        vecs.push_back(mk(2'b00, 3'b101, 64'h1,                64'hFFFF_FFFF_FFFF_FFFF, 64'h200,           64'h40,               0, 1, 0, 64'h240));
        vecs.push_back(mk(2'b00, 3'b111, 64'h1,                64'hFFFF_FFFF_FFFF_FFFF, 64'h200,           64'h40,               0, 0, 0, 64'h204));
        vecs.push_back(mk(2'b00, 3'b100, 64'h7,                64'h7,                64'h200,              64'h40,               0, 0, 0, 64'h204));
        vecs.push_back(mk(2'b00, 3'b101, 64'h7,                64'h7,                64'h200,              64'h40,               1, 1, 0, 64'h240));
        vecs.push_back(mk(2'b01, 3'b000, 64'h0,                64'h0,                64'h300,              64'hFFFF_FFFF_FFFF_FFF0, 1, 1, 0, 64'h2F0));
        vecs.push_back(mk(2'b10, 3'b000, 64'h1003,             64'h0,                64'h400,              64'h0,                1, 1, 0, 64'h1002));
        vecs.push_back(mk(2'b10, 3'b000, 64'h1000,             64'h0,                64'h400,              64'h7,                0, 1, 0, 64'h1006));
        vecs.push_back(mk(2'b00, 3'b010, 64'h9,                64'h9,                64'h500,              64'h10,               1, 0, 1, 64'h504));
        vecs.push_back(mk(2'b00, 3'b011, 64'h9,                64'h3,                64'h500,              64'h10,               0, 0, 1, 64'h504));
        vecs.push_back(mk(2'b11, 3'b000, 64'h9,                64'h9,                64'h500,              64'h10,               1, 0, 1, 64'h504));
        vecs.push_back(mk(2'b00, 3'b000, 64'h3,                64'h3,                64'hFFFF_FFFF_FFFF_FFF0, 64'h20,            1, 1, 0, 64'h10));
        vecs.push_back(mk(2'b01, 3'b000, 64'h0,                64'h0,                64'hFFFF_FFFF_FFFF_FFFC, 64'h8,             0, 1, 0, 64'h4));
        vecs.push_back(mk(2'b01, 3'b000, 64'h0,                64'h0,                64'h100,              64'h2,                1, 1, 0, 64'h102));

        // Reset state, observed while reset is still asserted.
        @(negedge clk);
        chk("reset out_valid_a", 132'(out_valid_a), 132'(0));
        chk("reset out_valid_b", 132'(out_valid_b), 132'(0));
        chk("reset in_ready_a", 132'(in_ready_a), 132'(1));
        chk("reset result_a", act_a(), 132'(0));
        chk("reset result_b", act_b(), 132'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Table vectors back to back with out_ready high: each edge drains the
        // previous result and accepts the next one.
        foreach (vecs[i]) begin
            set_in(vecs[i], 1'b1);
            step($sformatf("vec%0d", i));
        end
        in_valid = 1'b0;
        step("tbl_drain");
        step("tbl_idle");

        // Backpressure: hold for three cycles with a different request waiting,
        // then drain and accept in the same cycle.
        out_ready = 1'b0;
        set_in(vecs[0], 1'b1);
        step("bp_acc");
        set_in(vecs[3], 1'b1);
        repeat (3) step("bp_hold");
        out_ready = 1'b1;
        step("bp_swap");
        in_valid = 1'b0;
        step("bp_last");
        step("bp_idle");

        // Flush while full with a request pending: nothing accepted.
        out_ready = 1'b0;
        set_in(vecs[2], 1'b1);
        step("fl_acc");
        set_in(vecs[4], 1'b1);
        out_ready = 1'b1;
        flush     = 1'b1;
        step("fl_kill");
        flush    = 1'b0;
        in_valid = 1'b0;
        step("fl_after");

        // Asynchronous reset while full.
        out_ready = 1'b0;
        set_in(vecs[10], 1'b1);
        step("ar_acc");
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar out_valid_a", 132'(out_valid_a), 132'(0));
        chk("ar out_valid_b", 132'(out_valid_b), 132'(0));
        chk("ar in_ready_b", 132'(in_ready_b), 132'(1));
        chk("ar result_a", act_a(), 132'(0));
        chk("ar result_b", act_b(), 132'(0));
        m_full = 1'b0;
        exp_a_q.delete();
        exp_b_q.delete();
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        set_in(vecs[11], 1'b1);
        step("ar_reacc");
        in_valid = 1'b0;
        step("ar_drain");
        step("ar_idle");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
